// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default oversample ratio and
// idle line level. Used by both the transmitter and the receiver.
// Build option: UART_TX_PARITY_EN adds the PARITY state (widens encoding to 3 bits).
package uart_pkg;

    localparam int unsigned OversampleDefault = 16;
    localparam logic        IdleLevel         = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StStop   = 3'd3,
        StParity = 3'd4
    } uart_state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;
`endif

endpackage

// File: rtl/uart_tx_os.sv
// UART transmitter driven by the shared oversample tick (b_tick).
// Frame: start bit, DATA_BITS data bits LSB first, [even parity], one stop bit.
// Each bit lasts OVERSAMPLE b_tick pulses; tx is registered, one clk behind state.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = OversampleDefault
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
    localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic tick_end;
    assign tick_end = b_tick && (tick_q == TickLast);

    // Next-state logic: FSM, tick/bit counters and shift register.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                // A b_tick in the acceptance cycle is deliberately not counted.
                if (tx_start) begin
                    shift_d = tx_data;
                    tick_d  = '0;
                    bit_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StStart;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            StStart: begin
                if (tick_end) begin
                    tick_d  = '0;
                    state_d = StData;
                end else if (b_tick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StData: begin
                if (tick_end) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else if (b_tick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick_end) begin
                    tick_d  = '0;
                    state_d = StStop;
                end else if (b_tick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (tick_end) begin
                    tick_d  = '0;
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (b_tick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the current state; registering it gives the one-clk offset.
    always_comb begin
        tx_d = IdleLevel;
        case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = IdleLevel;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= IdleLevel;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_os.sv
// Self-checking bench for uart_tx_os: a line monitor decodes every frame at
// mid-bit and compares it against bytes queued when each request is driven.
module tb_uart_tx_os;

    localparam int unsigned DataBits = 8;
    localparam int unsigned Os       = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned ParBits  = 1;
`else
    localparam int unsigned ParBits  = 0;
`endif
    localparam int unsigned FrameTicks = (2 + DataBits + ParBits) * Os;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_tick = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx, tx_busy, tx_done;

    int unsigned      n_checks = 0;
    int unsigned      n_errors = 0;
    int unsigned      tick_div = 4;
    int unsigned      tick_ph = 0;
    bit               tick_en = 1'b0;
    logic [7:0]       exp_q[$];
    int unsigned      frames_seen = 0;
    int unsigned      done_count = 0;
    longint unsigned  cyc = 0;
    longint unsigned  last_fall = 0;
    longint unsigned  prev_fall = 0;

    uart_tx_os #(
        .DATA_BITS (DataBits),
        .OVERSAMPLE(Os)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .b_tick  (b_tick),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick source: every tick_div clks, or continuously high when tick_div is 1.
    always @(posedge clk) begin
        #1;
        if (!tick_en) begin
            b_tick = 1'b0;
        end else if (tick_div <= 1) begin
            b_tick = 1'b1;
        end else begin
            b_tick  = (tick_ph == 0);
            tick_ph = (tick_ph + 1) % tick_div;
        end
    end

    always @(negedge clk) if (tx_done === 1'b1) done_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sample the frame at mid-bit; a reset seen mid-frame abandons it.
    task automatic decode_frame();
        int unsigned bp;
        logic [15:0] bits;
        logic [7:0]  data;
        logic [7:0]  exp;
        bp = Os * ((tick_div == 0) ? 1 : tick_div);
        bits = '0;
        data = '0;
        prev_fall = last_fall;
        last_fall = cyc;
        for (int k = 0; k < int'(DataBits + ParBits + 2); k++) begin
            repeat ((k == 0) ? bp / 2 : bp) begin
                @(negedge clk);
                if (rst) return;
            end
            bits[k] = tx;
        end
        frames_seen++;
        for (int i = 0; i < int'(DataBits); i++) data[i] = bits[i+1];
        if (exp_q.size() == 0) begin
            check("unexpected_frame_queue_size", exp_q.size(), 1);
            return;
        end
        exp = exp_q.pop_front();
        check("start_bit", bits[0], 1'b0);
        check("data_byte", data, exp);
`ifdef UART_TX_PARITY_EN
        check("parity_bit", bits[DataBits+1], ^exp);
`endif
        check("stop_bit", bits[DataBits+ParBits+1], 1'b1);
    endtask

    initial begin : monitor
        logic prev_tx;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_tx = 1'b1;
                continue;
            end
            if (prev_tx === 1'b1 && tx === 1'b0) decode_frame();
            prev_tx = tx;
        end
    end

    task automatic send(input logic [7:0] b, input bit push);
        tx_data  = b;
        tx_start = 1'b1;
        if (push) exp_q.push_back(b);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
    endtask

    // Counts clks from the acceptance edge to the edge that raises tx_done.
    task automatic wait_done(input string tag, output int unsigned n);
        int unsigned busy_bad;
        int unsigned limit;
        limit = FrameTicks * tick_div + 50;
        busy_bad = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (tx_done) break;
            if (tx_busy !== 1'b1) busy_bad++;
            n++;
            if (n > limit) begin
                check({tag, "_done_timeout"}, tx_done, 1'b1);
                break;
            end
        end
        check({tag, "_busy_during_frame"}, busy_bad, 0);
        check({tag, "_busy_low_at_done"}, tx_busy, 1'b0);
        check({tag, "_tx_idle_at_done"}, tx, 1'b1);
    endtask

    task automatic check_len(input string tag, input int unsigned n);
        int unsigned lo, hi;
        if (tick_div <= 1) begin
            check({tag, "_frame_clks"}, n, FrameTicks);
        end else begin
            hi = FrameTicks * tick_div;
            lo = hi - tick_div + 1;
            if (n < lo || n > hi) check({tag, "_frame_clks_in_range"}, n, hi);
            else check({tag, "_frame_clks_in_range"}, n, n);
        end
    endtask

    initial begin : stimulus
        int unsigned n, n1, dc0;
        tick_en = 1'b1;
        tick_div = 4;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", tx_busy, 1'b0);
        check("reset_done", tx_done, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single frame 0x55, ticks every 4 clks.
        dc0 = done_count;
        send(8'h55, 1'b1);
        wait_done("f55", n);
        check_len("f55", n);
        @(negedge clk);
        check("f55_done_one_clk", tx_done, 1'b0);
        check("f55_done_count", done_count - dc0, 1);
        repeat (10) @(negedge clk);

        // Back-to-back: second request lands in the tx_done cycle.
        send(8'hA3, 1'b1);
        wait_done("fA3", n1);
        check_len("fA3", n1);
        send(8'h0F, 1'b1);
        wait_done("f0F", n);
        check_len("f0F", n);
        check("b2b_fall_gap_clks", 32'(last_fall - prev_fall), n1 + 1);
        repeat (10) @(negedge clk);

        // tx_start held, tx_data scrambled during the frame.
        tx_data  = 8'h81;
        tx_start = 1'b1;
        exp_q.push_back(8'h81);
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            if (tx_done) break;
            n++;
            tx_data = 8'($urandom);
            if (n > FrameTicks * tick_div + 50) begin
                check("held_done_timeout", tx_done, 1'b1);
                break;
            end
        end
        check_len("f81", n);
        tx_data = 8'h3C;
        exp_q.push_back(8'h3C);
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        wait_done("f3C", n);
        check_len("f3C", n);
        repeat (10) @(negedge clk);

        // Reset in the middle of data bit 3 of 0xFF.
        send(8'hFF, 1'b0);
        repeat (4 * Os * tick_div + Os * tick_div / 2) @(negedge clk);
        check("ff_busy_mid_frame", tx_busy, 1'b1);
        dc0 = done_count;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", tx_busy, 1'b0);
        check("midrst_done", tx_done, 1'b0);
        rst = 1'b0;
        repeat (FrameTicks * tick_div) @(negedge clk);
        check("midrst_no_done", done_count - dc0, 0);
        send(8'h00, 1'b1);
        wait_done("f00", n);
        check_len("f00", n);
        repeat (10) @(negedge clk);

        // b_tick continuously high.
        tick_div = 1;
        repeat (3) @(negedge clk);
        send(8'hC6, 1'b1);
        wait_done("fC6", n);
        check_len("fC6", n);
        repeat (5) @(negedge clk);
        send(8'h07, 1'b1);
        wait_done("f07", n);
        check_len("f07", n);
        repeat (5) @(negedge clk);
        send(8'h03, 1'b1);
        wait_done("f03", n);
        check_len("f03", n);
        repeat (20) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        check("frames_decoded", frames_seen, 9);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
